imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream and writes it into instruction memory
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [23:0]   part_q, part_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic          cpu_q, cpu_d;
    logic          xfer;

    assign byte_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA) || (state_q == CHK);
    assign xfer       = byte_valid && byte_ready;
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wd    = wd_q;
    assign cpu_rst_n  = cpu_q;
    assign busy       = byte_ready || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        part_d  = part_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR_HI;
                    idx_d   = '0;
                    chk_d   = '0;
                    bcnt_d  = '0;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    n_d     = {byte_data, n_q[7:0]};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    n_d     = {n_q[15:8], byte_data};
                    state_d = (n_d == 16'd0) ? CHK : (32'(n_d) > 32'(DEPTH)) ? ERR : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    chk_d  = chk_q ^ byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    part_d = {part_q[15:0], byte_data};
                    if (bcnt_q == 2'd3) begin
                        addr_d  = 32'({idx_q, 2'b00});
                        wd_d    = {part_q, byte_data};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + IW'(1);
                state_d = (32'(idx_d) < 32'(n_q)) ? DATA : CHK;
            end
            CHK: begin
                if (xfer) state_d = (byte_data == chk_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        cpu_d = (state_d == DONE);
    end

    // Async reset kills an in-flight WRITE immediately since imem_we decodes state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            part_q  <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            part_q  <= part_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            cpu_q   <= cpu_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams checked against a stream-level model of the loader
module tb_imem_loader;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, cpu_rst_n, busy, done, err;
    logic [31:0] imem_addr, imem_wd;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    int         compares = 0;
    int         fails = 0;
    int         n_writes = 0;
    int         exp_nw;
    logic       exp_done, exp_err;
    logic [7:0] exp_chk;
    logic [7:0] happy[$], bad[$], over[$], empty[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [7:0] s[$]);
        int n;
        logic [31:0] d;
        n = {s[0], s[1]};
        exp_q.delete();
        exp_nw = 0;
        exp_chk = 8'h00;
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            for (int w = 0; w < n; w++) begin
                d = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
                exp_chk ^= s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
                exp_q.push_back('{a: 32'(4 * w), d: d});
                exp_nw++;
            end
            exp_done = (s[2+4*n] == exp_chk);
            exp_err  = !exp_done;
        end
    endtask

    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_t e;
            n_writes++;
            compares++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL extra_write actual=%h:%h required=none", imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.a || imem_wd !== e.d) begin
                    fails++;
                    $display("FAIL write actual=%h:%h required=%h:%h", imem_addr, imem_wd, e.a, e.d);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int t;
        for (int i = 0; i < gaps; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic finish_checks(input string nm);
        chk({nm, "_done"}, 32'(done), 32'(exp_done));
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
        chk({nm, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_nwrites"}, 32'(n_writes), 32'(exp_nw));
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input string nm, input logic [7:0] s[$], input int maxgap);
        model(s);
        n_writes = 0;
        pulse_start();
        foreach (s[i]) send_byte(s[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
        finish_checks(nm);
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_ready"}, 32'(byte_ready), 32'd0);
        chk({nm, "_we"}, 32'(imem_we), 32'd0);
        chk({nm, "_addr"}, imem_addr, 32'd0);
        chk({nm, "_wd"}, imem_wd, 32'd0);
        chk({nm, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        happy = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04, 8'h8D};
        bad   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04, 8'h8C};
        over  = '{8'h01, 8'h01};
        empty = '{8'h00, 8'h00, 8'h00};

        // Model pins: the XOR of the eight data bytes is 8D, so 8D is the passing checksum.
        model(happy);
        chk("pin_w0_data", exp_q[0].d, 32'h20080005);
        chk("pin_w1_addr", exp_q[1].a, 32'h00000004);
        chk("pin_w1_data", exp_q[1].d, 32'hAC080004);
        chk("pin_checksum", 32'(exp_chk), 32'h8D);
        model(over);
        chk("pin_oversize_err", 32'(exp_err), 32'd1);
        exp_q.delete();

        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);
        chk("idle_after_reset_ready", 32'(byte_ready), 32'd0);

        run("happy", happy, 0);
        run("bad_chk", bad, 0);
        run("oversize", over, 0);
        run("empty", empty, 0);
        run("stalls", happy, 3);

        model(happy);
        n_writes = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(happy[i], 0);
        #1 rst = 1'b0;
        #1 reset_checks("midload_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midload_idle_busy", 32'(busy), 32'd0);
        chk("midload_nwrites", 32'(n_writes), 32'd1);
        run("after_reset", happy, 0);

        model(happy);
        n_writes = 0;
        pulse_start();
        chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        send_byte(happy[0], 0);
        send_byte(happy[1], 0);
        pulse_start();
        for (int i = 2; i < happy.size(); i++) send_byte(happy[i], 0);
        finish_checks("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
